player_dir_encoder: RTL

//  Converts one player's four raw direction buttons into the 4-bit one-hot p_info

---
 rtl/tron_pkg.sv | 23 ++
 rtl/player_dir_encoder_if.sv | 25 ++
 rtl/btn_debounce.sv | 51 +++++
 rtl/player_dir_encoder.sv | 81 ++++++++
 4 files changed

// File: rtl/tron_pkg.sv
// Direction codes and helpers shared by the player direction, update and draw logic.
// Directions are one-hot so draw_object can decode them without a lookup.
package tron_pkg;

    localparam logic [3:0] DIR_STOP  = 4'b0000;
    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    function automatic logic [3:0] reverse_dir(input logic [3:0] dir);
        logic [3:0] rev;
        case (dir)
            DIR_UP:    rev = DIR_DOWN;
            DIR_DOWN:  rev = DIR_UP;
            DIR_LEFT:  rev = DIR_RIGHT;
            DIR_RIGHT: rev = DIR_LEFT;
            default:   rev = DIR_STOP;
        endcase
        return rev;
    endfunction

endpackage

// File: rtl/player_dir_encoder_if.sv
// Control, button and direction-code bundle between the board/game logic and one encoder.
// master drives controls and raw buttons; slave (the encoder) returns p_info/pending.
interface player_dir_encoder_if;

    logic       dflt;
    logic       run;
    logic       frame_tick;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic [3:0] p_info;
    logic       pending;

    modport master (
        output dflt, run, frame_tick, btn_up, btn_down, btn_left, btn_right,
        input  p_info, pending
    );

    modport slave (
        input  dflt, run, frame_tick, btn_up, btn_down, btn_left, btn_right,
        output p_info, pending
    );

endinterface

// File: rtl/btn_debounce.sv
// Synchronises one raw button and emits a 1-cycle press pulse once it has been stably high.
// Press appears DEBOUNCE_CYCLES+2 edges after the button is first sampled; release is silent.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST_MISMATCH = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    logic w_sync_out;
    logic w_mismatch;
    logic w_flip;

    assign w_sync_out = r_sync[1];
    assign w_mismatch = (w_sync_out != r_stable);
    // The flip happens on the DEBOUNCE_CYCLES-th consecutive mismatching cycle.
    assign w_flip     = w_mismatch && (r_cnt == LAST_MISMATCH);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync   <= 2'b00;
            r_stable <= 1'b0;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], btn_raw};
            r_press <= w_flip && w_sync_out;
            if (!w_mismatch) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_cnt    <= '0;
                r_stable <= w_sync_out;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign press = r_press;

endmodule

// File: rtl/player_dir_encoder.sv
// Turns four debounced buttons into a frame-stable one-hot direction, rejecting reversals.
// One queued turn commits on frame_tick&&run; p_info/pending are registered from next-state.
module player_dir_encoder
    import tron_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 250000,
    parameter logic [3:0] START_DIR       = DIR_RIGHT
) (
    input  logic                 clock,
    input  logic                 reset,
    player_dir_encoder_if.slave  bus
);

    logic [3:0] w_press;
    logic [3:0] w_cand;
    logic       w_legal;
    logic [3:0] w_req_queued;
    logic [3:0] w_cur_next;
    logic [3:0] w_req_next;

    logic [3:0] r_cur_dir;
    logic [3:0] r_req;
    logic [3:0] r_p_info;
    logic       r_pending;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .clock(clock), .reset(reset), .btn_raw(bus.btn_up), .press(w_press[0])
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
        .clock(clock), .reset(reset), .btn_raw(bus.btn_down), .press(w_press[1])
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
        .clock(clock), .reset(reset), .btn_raw(bus.btn_left), .press(w_press[2])
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
        .clock(clock), .reset(reset), .btn_raw(bus.btn_right), .press(w_press[3])
    );

    always_comb begin
        w_cand = DIR_STOP;
        if (w_press[0])      w_cand = DIR_UP;
        else if (w_press[1]) w_cand = DIR_DOWN;
        else if (w_press[2]) w_cand = DIR_LEFT;
        else if (w_press[3]) w_cand = DIR_RIGHT;
    end

    // Legality uses the committed direction, so a queued turn cannot enable a reversal.
    assign w_legal = (w_cand != DIR_STOP) && (w_cand != r_cur_dir)
                     && (w_cand != reverse_dir(r_cur_dir));

    always_comb begin
        w_req_queued = w_legal ? w_cand : r_req;
        w_cur_next   = r_cur_dir;
        w_req_next   = w_req_queued;
        if (bus.dflt) begin
            w_cur_next = START_DIR;
            w_req_next = DIR_STOP;
        end else if (bus.frame_tick && bus.run && (w_req_queued != DIR_STOP)) begin
            w_cur_next = w_req_queued;
            w_req_next = DIR_STOP;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cur_dir <= START_DIR;
            r_req     <= DIR_STOP;
            r_p_info  <= DIR_STOP;
            r_pending <= 1'b0;
        end else begin
            r_cur_dir <= w_cur_next;
            r_req     <= w_req_next;
            r_p_info  <= bus.run ? w_cur_next : DIR_STOP;
            r_pending <= (w_req_next != DIR_STOP);
        end
    end

    assign bus.p_info  = r_p_info;
    assign bus.pending = r_pending;

endmodule
